branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

ID-stage branch resolution controller for the 5-stage pipelined MIPS core. It owns the 32-bit equality compare used by early branch resolution and detects data hazards on branch operands. It stalls IF/ID for the required number of cycles, forwards the EX/MEM ALU result into the compare, and issues the PC-select and IF flush for taken BEQ/BNE. It also keeps branch statistics counters.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register index, 16-bit counters).
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  valid instruction in IF/ID
- id_beq, id_bne  in  1  decoded branch type; both high is treated as BEQ
- id_rs, id_rt  in  5  source register indices
- id_rs_data, id_rt_data  in  32  register file read data (regfile is write-first, so WB needs no forwarding)
- id_pc_plus4  in  32  PC+4 of the branch
- id_imm  in  32  sign-extended immediate
- ex_regwrite, ex_memread  in  1  / ex_rd  in  5  : ID/EX destination info
- mem_regwrite, mem_memread  in  1  / mem_rd  in  5  / mem_alu_result  in  32  : EX/MEM info and result
- stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX
- pc_src  out  1  select branch_target as next PC
- flush  out  1  squash IF/ID (equals pc_src)
- branch_target  out  32  id_pc_plus4 + (id_imm << 2), modulo 2^32
- branch_count, taken_count  out  16  resolved / taken branch counters

## Operation
- is_br = id_valid & (id_beq | id_bne). A register matches when its index is nonzero and equals id_rs or id_rt. $0 never creates a hazard.
- The stall requirement N is evaluated in IDLE:
  - EX match with ex_regwrite & ex_memread: N=2.
  - EX match with ex_regwrite & !ex_memread: N=1.
  - Otherwise, MEM match with mem_regwrite & mem_memread: N=1.
  - Otherwise N=0.
- FSM states are IDLE, STALL and RESOLVE. A 2-bit counter cnt tracks remaining stalls.
  - IDLE, !is_br: all outputs 0.
  - IDLE, is_br, N=0: resolve in this cycle and stay in IDLE.
  - IDLE, is_br, N>0: stall=1 and cnt<=N-1. Next state is RESOLVE if N==1, otherwise STALL.
  - STALL: stall=1 and cnt<=cnt-1. Next state is RESOLVE when cnt==1.
  - RESOLVE: stall=0. Resolve the branch, then go to IDLE.
- Resolving a branch does the following:
  - Each compare operand is mem_alu_result if that register matches mem_rd with mem_regwrite & !mem_memread; otherwise it is the regfile data.
  - eq = (opA == opB). taken = id_beq ? eq : !eq.
  - pc_src = flush = taken.
  - branch_count increments. taken_count increments if taken. Both counters wrap 0xFFFF -> 0.
- If id_valid drops while in STALL or RESOLVE (external squash), go to IDLE that cycle. In that case there is no resolve, no counter update, and stall=0.
- branch_target is combinational and always driven. It is meaningful only when pc_src=1.

## Timing
- stall, pc_src and flush are combinational from state and inputs, so they act in the same cycle.
- Branch with no hazard: resolved in its first ID cycle.
- ALU producer in EX: 1 stall cycle, then resolved using EX/MEM forwarding.
- Load in EX: 2 stalls, then resolved from the regfile.
- Load in MEM: 1 stall.
- Counters update on the clock edge that ends the resolve cycle.
- Reset:
  - While rst is high, stall, pc_src and flush are forced to 0.
  - On the edge: state<=IDLE, cnt<=0, branch_count<=0, taken_count<=0.
  - Reset mid-STALL aborts the branch, with no counter update.
- Back-to-back branches: a branch arriving in IDLE the cycle after RESOLVE is evaluated normally.

## Test plan
- BEQ, rs=rt=5, regfile data 0x1234 on both, no hazards, pc_plus4=0x100, imm=0x10 -> same cycle pc_src=1, flush=1, target=0x140, stall=0; counters 1/1.
- BNE, rs=3 (0xA), rt=4 (0xA), no hazards -> pc_src=0; branch_count increments, taken_count does not.
- BEQ whose rs matches ex_rd (ALU op, ex_memread=0); next cycle mem_rd=rs with mem_alu_result equal to rt data -> stall for exactly 1 cycle, then pc_src=1 using the forwarded value.
- BEQ whose rt matches ex_rd with ex_memread=1 -> stall=1 for 2 cycles, then resolve from regfile data. Also: ex_rd=0 with rs=0 -> no stall.
- Reset asserted in the 1st STALL cycle of a load-use branch -> outputs 0 during reset, state IDLE afterwards, counters 0. Also: id_valid dropped in STALL -> no resolve, counters unchanged.
- 65536 resolved taken branches -> both counters wrap to 0x0000.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolver: equality compare, branch-operand hazard stalls, EX/MEM forwarding, statistics counters.
// Latency: stall/pc_src/flush are combinational in the current cycle; counters update on the edge ending the resolve cycle.
// Backpressure: holds PC and IF/ID with stall for 0-2 cycles; dropping id_valid aborts a pending branch.
module branch_resolve_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_beq,
  input  logic        id_bne,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] id_imm,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  output logic        stall,
  output logic        pc_src,
  output logic        flush,
  output logic [31:0] branch_target,
  output logic [15:0] branch_count,
  output logic [15:0] taken_count
);

  typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] taken_count_q, taken_count_d;

  logic        is_br;
  logic        ex_match, mem_match;
  logic [1:0]  need;
  logic        fwd_a, fwd_b;
  logic [31:0] op_a, op_b;
  logic        taken;
  logic        stall_c, resolve_c;

  assign is_br = id_valid & (id_beq | id_bne);

  // Hazard detection: how many cycles the branch must wait for its operands ($0 never hazards)
  always_comb begin
    ex_match  = (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
    mem_match = (mem_rd != 5'd0) && ((mem_rd == id_rs) || (mem_rd == id_rt));
    need      = 2'd0;
    if (ex_match && ex_regwrite && ex_memread)
      need = 2'd2;
    else if (ex_match && ex_regwrite)
      need = 2'd1;
    else if (mem_match && mem_regwrite && mem_memread)
      need = 2'd1;
  end

  // Operand select with EX/MEM ALU forwarding, then compare; BEQ wins when both types are set
  always_comb begin
    fwd_a = (mem_rd != 5'd0) && (mem_rd == id_rs) && mem_regwrite && !mem_memread;
    fwd_b = (mem_rd != 5'd0) && (mem_rd == id_rt) && mem_regwrite && !mem_memread;
    op_a  = fwd_a ? mem_alu_result : id_rs_data;
    op_b  = fwd_b ? mem_alu_result : id_rt_data;
    taken = id_beq ? (op_a == op_b) : (op_a != op_b);
  end

  // Next-state, stall and resolve decisions; a squashed branch (id_valid low) returns to IDLE silently
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    resolve_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_br) begin
          if (need == 2'd0) begin
            resolve_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = need - 2'd1;
            state_d = (need == 2'd1) ? RESOLVE : STALL;
          end
        end
      end
      STALL: begin
        if (!id_valid) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q == 2'd1)
            state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        state_d   = IDLE;
        resolve_c = id_valid;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
    branch_count_d = branch_count_q + {15'd0, resolve_c};
    taken_count_d  = taken_count_q + {15'd0, resolve_c & taken};
  end

  // State and counter registers, synchronous reset aborts any pending branch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 2'd0;
      branch_count_q <= 16'd0;
      taken_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign stall         = stall_c & ~rst;
  assign pc_src        = resolve_c & taken & ~rst;
  assign flush         = pc_src;
  assign branch_target = id_pc_plus4 + {id_imm[29:0], 2'b00};
  assign branch_count  = branch_count_q;
  assign taken_count   = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: table of single-cycle vectors plus multi-cycle sequences.
// Latency: outputs checked mid-cycle after inputs settle, counters checked after the following edge.
// Backpressure: stall sequences hold the branch inputs stable as the frozen IF/ID would.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_beq, id_bne;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_rs_data, id_rt_data, id_pc_plus4, id_imm;
  logic        ex_regwrite, ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_regwrite, mem_memread;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic        stall, pc_src, flush;
  logic [31:0] branch_target;
  logic [15:0] branch_count, taken_count;

  int checks = 0;
  int errors = 0;
  int exp_bc = 0;
  int exp_tc = 0;

  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_beq(id_beq), .id_bne(id_bne),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_pc_plus4(id_pc_plus4), .id_imm(id_imm),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result),
    .stall(stall), .pc_src(pc_src), .flush(flush), .branch_target(branch_target),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, beq, bne;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, pc4, imm;
    logic        exw, exr;
    logic [4:0]  exrd;
    logic        memw, memr;
    logic [4:0]  memrd;
    logic [31:0] memres;
    logic        e_stall, e_pc;
    logic [31:0] e_tgt;
    logic        e_res;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(
      logic valid, logic beq, logic bne, logic [4:0] rs, logic [4:0] rt,
      logic [31:0] rsd, logic [31:0] rtd, logic [31:0] pc4, logic [31:0] imm,
      logic exw, logic exr, logic [4:0] exrd, logic memw, logic memr, logic [4:0] memrd,
      logic [31:0] memres, logic e_stall, logic e_pc, logic [31:0] e_tgt, logic e_res);
    vec_t v;
    v.valid = valid; v.beq = beq; v.bne = bne; v.rs = rs; v.rt = rt;
    v.rsd = rsd; v.rtd = rtd; v.pc4 = pc4; v.imm = imm;
    v.exw = exw; v.exr = exr; v.exrd = exrd;
    v.memw = memw; v.memr = memr; v.memrd = memrd; v.memres = memres;
    v.e_stall = e_stall; v.e_pc = e_pc; v.e_tgt = e_tgt; v.e_res = e_res;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_in();
    id_valid = 0; id_beq = 0; id_bne = 0; id_rs = 0; id_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_pc_plus4 = 0; id_imm = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0; mem_alu_result = 0;
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_beq = v.beq; id_bne = v.bne; id_rs = v.rs; id_rt = v.rt;
    id_rs_data = v.rsd; id_rt_data = v.rtd; id_pc_plus4 = v.pc4; id_imm = v.imm;
    ex_regwrite = v.exw; ex_memread = v.exr; ex_rd = v.exrd;
    mem_regwrite = v.memw; mem_memread = v.memr; mem_rd = v.memrd; mem_alu_result = v.memres;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic e_stall, input logic e_pc);
    #2;
    check({name, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
    check({name, ".pc_src"}, {31'd0, pc_src}, {31'd0, e_pc});
    check({name, ".flush"}, {31'd0, flush}, {31'd0, e_pc});
  endtask

  task automatic chk_cnt(input string name);
    check({name, ".branch_count"}, {16'd0, branch_count}, exp_bc[31:0] & 32'hFFFF);
    check({name, ".taken_count"}, {16'd0, taken_count}, exp_tc[31:0] & 32'hFFFF);
  endtask

  initial begin
    //                 v  beq bne rs  rt  rsd           rtd           pc4           imm           exw exr exrd memw memr memrd memres  stl pc tgt           res
    vecs[0] = mk(1, 1, 0, 5,  5,  32'h1234,     32'h1234,     32'h100,      32'h10,       0, 0, 0,  0, 0, 0,  32'h0,  0, 1, 32'h140,      1);
    vecs[1] = mk(1, 0, 1, 3,  4,  32'hA,        32'hA,        32'h200,      32'hFFFFFFFF, 0, 0, 0,  0, 0, 0,  32'h0,  0, 0, 32'h1FC,      1);
    vecs[2] = mk(0, 1, 0, 5,  5,  32'h1,        32'h1,        32'h100,      32'h10,       0, 0, 0,  0, 0, 0,  32'h0,  0, 0, 32'h140,      0);
    vecs[3] = mk(1, 1, 0, 0,  0,  32'h0,        32'h0,        32'h0,        32'h40000000, 1, 1, 0,  0, 0, 0,  32'h0,  0, 1, 32'h0,        1);
    vecs[4] = mk(1, 0, 1, 1,  2,  32'h1,        32'h2,        32'h300,      32'h1,        0, 0, 0,  1, 0, 1,  32'h2,  0, 0, 32'h304,      1);
    vecs[5] = mk(1, 1, 1, 6,  7,  32'h5,        32'h6,        32'h400,      32'h2,        0, 0, 0,  0, 0, 0,  32'h0,  0, 0, 32'h408,      1);
    vecs[6] = mk(1, 1, 0, 6,  7,  32'h5,        32'h5,        32'h10,       32'hFFFFFFFE, 0, 1, 6,  0, 0, 0,  32'h0,  0, 1, 32'h8,        1);
    vecs[7] = mk(1, 0, 0, 6,  7,  32'h5,        32'h5,        32'h10,       32'h0,        1, 1, 6,  0, 0, 0,  32'h0,  0, 0, 32'h10,       0);

    // Reset with a taken branch present: outputs must be held low
    clear_in();
    rst = 1;
    drive(vecs[0]);
    chk_out("reset_hold", 0, 0);
    step();
    step();
    rst = 0;
    clear_in();
    chk_out("idle_after_reset", 0, 0);
    chk_cnt("reset_counters");

    // Table-driven single-cycle cases
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      chk_out($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_pc);
      check($sformatf("vec%0d.target", i), branch_target, vecs[i].e_tgt);
      if (vecs[i].e_res) exp_bc++;
      if (vecs[i].e_res && vecs[i].e_pc) exp_tc++;
      step();
    end
    clear_in();
    chk_cnt("table_counters");

    // ALU producer in EX: one stall, then resolve from the forwarded EX/MEM result
    id_valid = 1; id_beq = 1; id_rs = 8; id_rt = 9; id_rs_data = 32'h0; id_rt_data = 32'h55;
    id_pc_plus4 = 32'h500; id_imm = 32'h4;
    ex_regwrite = 1; ex_rd = 8;
    chk_out("alu_ex.c1", 1, 0);
    step();
    ex_regwrite = 0; ex_rd = 0;
    mem_regwrite = 1; mem_rd = 8; mem_alu_result = 32'h55;
    chk_out("alu_ex.c2", 0, 1);
    check("alu_ex.target", branch_target, 32'h510);
    step();
    exp_bc++; exp_tc++;
    clear_in();
    chk_out("alu_ex.after", 0, 0);
    chk_cnt("alu_ex");

    // Load in EX on rt: two stalls, then resolve from regfile
    id_valid = 1; id_beq = 1; id_rs = 10; id_rt = 11; id_rs_data = 32'h7; id_rt_data = 32'h0;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 11;
    chk_out("load_ex.c1", 1, 0);
    step();
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 11;
    chk_out("load_ex.c2", 1, 0);
    step();
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    id_rt_data = 32'h7;
    chk_out("load_ex.c3", 0, 1);
    step();
    exp_bc++; exp_tc++;
    // Back-to-back: no-hazard BNE immediately after RESOLVE, not taken
    id_beq = 0; id_bne = 1; id_rs = 2; id_rt = 3; id_rs_data = 32'h9; id_rt_data = 32'h9;
    chk_out("b2b", 0, 0);
    step();
    exp_bc++;
    clear_in();
    chk_cnt("load_ex");

    // Load in MEM: one stall, BNE with differing operands taken
    id_valid = 1; id_bne = 1; id_rs = 12; id_rt = 13; id_rs_data = 32'h1; id_rt_data = 32'h2;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 13;
    chk_out("load_mem.c1", 1, 0);
    step();
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    chk_out("load_mem.c2", 0, 1);
    step();
    exp_bc++; exp_tc++;
    clear_in();
    chk_cnt("load_mem");

    // id_valid dropped in STALL: no resolve, counters unchanged, back in IDLE
    id_valid = 1; id_beq = 1; id_rs = 14; id_rt = 15; id_rs_data = 32'h3; id_rt_data = 32'h3;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 14;
    chk_out("squash.c1", 1, 0);
    step();
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    id_valid = 0;
    chk_out("squash.c2", 0, 0);
    step();
    chk_cnt("squash");
    id_valid = 1;
    chk_out("squash.idle", 0, 1);
    step();
    exp_bc++; exp_tc++;
    clear_in();
    chk_cnt("squash_after");

    // Reset in first STALL cycle of a load-use branch
    id_valid = 1; id_beq = 1; id_rs = 16; id_rt = 17; id_rs_data = 32'h4; id_rt_data = 32'h4;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 17;
    chk_out("rst_mid.c1", 1, 0);
    step();
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    rst = 1;
    chk_out("rst_mid.during", 0, 0);
    step();
    rst = 0;
    exp_bc = 0; exp_tc = 0;
    chk_cnt("rst_mid");
    chk_out("rst_mid.idle", 0, 1);
    step();
    exp_bc++; exp_tc++;
    clear_in();
    chk_cnt("rst_mid_after");

    // Counter wrap: 65536 taken branches from zero
    rst = 1;
    step();
    rst = 0;
    drive(vecs[0]);
    repeat (65535) step();
    exp_bc = 32'hFFFF; exp_tc = 32'hFFFF;
    chk_cnt("wrap_pre");
    step();
    exp_bc = 0; exp_tc = 0;
    chk_cnt("wrap");
    clear_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
